skin_likelihood_classifier: RTL

- Downstream consumer of the Gaussian Cb/Cr distance stream (10-bit distance value plus 1-clk-delayed enable).
- Maps distance A to likelihood L ≈ 255·exp(−A/128) through an internal 64-entry ROM.
- Thresholds L into a per-pixel skin mask and accumulates a per-frame skin-pixel count for the figure-recognition back end.

---
 rtl/skin_likelihood_classifier_if.sv | 38 +++
 rtl/skin_likelihood_classifier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/skin_likelihood_classifier_if.sv
// Pixel-stream interface for skin_likelihood_classifier.
// The master drives the Gaussian distance stream and frame sync; the slave returns
// the mask stream and the frame statistics.
// Optional macro: LIKELIHOOD_OUT_EN adds the likelihood_out signal.
interface skin_likelihood_classifier_if #(
    parameter int unsigned CNT_W = 20
);
    logic [9:0]       gauss_A_in;
    logic             ien;
    logic             vsync_in;
    logic             skin_mask;
    logic             oen;
    logic [CNT_W-1:0] skin_count;
    logic             count_valid;
`ifdef LIKELIHOOD_OUT_EN
    logic [7:0]       likelihood_out;

    modport master (
        output gauss_A_in, ien, vsync_in,
        input  skin_mask, oen, skin_count, count_valid, likelihood_out
    );

    modport slave (
        input  gauss_A_in, ien, vsync_in,
        output skin_mask, oen, skin_count, count_valid, likelihood_out
    );
`else
    modport master (
        output gauss_A_in, ien, vsync_in,
        input  skin_mask, oen, skin_count, count_valid
    );

    modport slave (
        input  gauss_A_in, ien, vsync_in,
        output skin_mask, oen, skin_count, count_valid
    );
`endif
endinterface

// File: rtl/skin_likelihood_classifier.sv
// Skin likelihood classifier.
// Maps the Gaussian Cb/Cr distance to a likelihood through a 64-entry exp ROM,
// thresholds it into a per-pixel skin mask (2-clk pipeline), and counts skin pixels
// per frame, reporting the count on each rising edge of vsync_in.
// Optional macro: LIKELIHOOD_OUT_EN exposes the stage-2 likelihood on likelihood_out.
module skin_likelihood_classifier #(
    parameter logic [7:0]  TH    = 8'd94,
    parameter int unsigned CNT_W = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    skin_likelihood_classifier_if.slave    bus
);

    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    logic [5:0]       w_rom_idx;
    logic [7:0]       w_rom_l;
    logic             w_unused_lsb;
    logic             w_fs;
    logic             w_hit;

    logic [7:0]       r_l;
    logic             r_v1;
    logic             r_skin_mask;
    logic             r_oen;
    logic             r_vs_d;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_skin_count;
    logic             r_count_valid;
`ifdef LIKELIHOOD_OUT_EN
    logic [7:0]       r_likelihood;
`endif

    // The low 4 distance bits fall below the ROM resolution.
    assign w_rom_idx    = bus.gauss_A_in[9:4];
    assign w_unused_lsb = ^bus.gauss_A_in[3:0];

    // Likelihood ROM: round(255 * exp(-16*i/128)); entries 50..63 round to 0.
    always_comb begin
        w_rom_l = 8'd0;
        case (w_rom_idx)
            6'd0:  w_rom_l = 8'd255;
            6'd1:  w_rom_l = 8'd225;
            6'd2:  w_rom_l = 8'd199;
            6'd3:  w_rom_l = 8'd175;
            6'd4:  w_rom_l = 8'd155;
            6'd5:  w_rom_l = 8'd136;
            6'd6:  w_rom_l = 8'd120;
            6'd7:  w_rom_l = 8'd106;
            6'd8:  w_rom_l = 8'd94;
            6'd9:  w_rom_l = 8'd83;
            6'd10: w_rom_l = 8'd73;
            6'd11: w_rom_l = 8'd64;
            6'd12: w_rom_l = 8'd57;
            6'd13: w_rom_l = 8'd50;
            6'd14: w_rom_l = 8'd44;
            6'd15: w_rom_l = 8'd39;
            6'd16: w_rom_l = 8'd35;
            6'd17: w_rom_l = 8'd30;
            6'd18: w_rom_l = 8'd27;
            6'd19: w_rom_l = 8'd24;
            6'd20: w_rom_l = 8'd21;
            6'd21: w_rom_l = 8'd18;
            6'd22: w_rom_l = 8'd16;
            6'd23: w_rom_l = 8'd14;
            6'd24: w_rom_l = 8'd13;
            6'd25: w_rom_l = 8'd11;
            6'd26: w_rom_l = 8'd10;
            6'd27: w_rom_l = 8'd9;
            6'd28: w_rom_l = 8'd8;
            6'd29: w_rom_l = 8'd7;
            6'd30: w_rom_l = 8'd6;
            6'd31: w_rom_l = 8'd5;
            6'd32: w_rom_l = 8'd5;
            6'd33: w_rom_l = 8'd4;
            6'd34: w_rom_l = 8'd4;
            6'd35: w_rom_l = 8'd3;
            6'd36: w_rom_l = 8'd3;
            6'd37: w_rom_l = 8'd2;
            6'd38: w_rom_l = 8'd2;
            6'd39: w_rom_l = 8'd2;
            6'd40: w_rom_l = 8'd2;
            6'd41: w_rom_l = 8'd2;
            6'd42: w_rom_l = 8'd1;
            6'd43: w_rom_l = 8'd1;
            6'd44: w_rom_l = 8'd1;
            6'd45: w_rom_l = 8'd1;
            6'd46: w_rom_l = 8'd1;
            6'd47: w_rom_l = 8'd1;
            6'd48: w_rom_l = 8'd1;
            6'd49: w_rom_l = 8'd1;
            default: w_rom_l = 8'd0;
        endcase
    end

    // Stage 1: registered ROM lookup and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_l  <= 8'd0;
            r_v1 <= 1'b0;
        end else begin
            r_l  <= w_rom_l;
            r_v1 <= bus.ien;
        end
    end

    // Stage 2: threshold into the mask; bubbles force the mask low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_skin_mask <= 1'b0;
            r_oen       <= 1'b0;
        end else begin
            r_skin_mask <= r_v1 & (r_l >= TH);
            r_oen       <= r_v1;
        end
    end

`ifdef LIKELIHOOD_OUT_EN
    // Stage 2 likelihood copy, zero outside valid cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_likelihood <= 8'd0;
        end else begin
            r_likelihood <= r_v1 ? r_l : 8'd0;
        end
    end

    assign bus.likelihood_out = r_likelihood;
`endif

    // A skin pixel present at the frame edge belongs to the new frame.
    assign w_fs  = bus.vsync_in & ~r_vs_d;
    assign w_hit = r_oen & r_skin_mask;

    // Frame-edge detect and saturating per-frame skin accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_d        <= 1'b0;
            r_acc         <= '0;
            r_skin_count  <= '0;
            r_count_valid <= 1'b0;
        end else begin
            r_vs_d <= bus.vsync_in;
            if (w_fs) begin
                r_skin_count  <= r_acc;
                r_count_valid <= 1'b1;
                r_acc         <= CNT_W'(w_hit);
            end else begin
                r_count_valid <= 1'b0;
                if (w_hit && (r_acc != ACC_MAX)) begin
                    r_acc <= r_acc + CNT_W'(1);
                end
            end
        end
    end

    assign bus.skin_mask   = r_skin_mask;
    assign bus.oen         = r_oen;
    assign bus.skin_count  = r_skin_count;
    assign bus.count_valid = r_count_valid;

endmodule
